// File: rtl/io_port_register.sv
// Basic-computer I/O port: INPR/FGI and OUTR/FGO with device valid/ready, IEN/IRQ, sticky error, counters.
// Latency: all state updates on the clk edge after the command/handshake; status outputs are combinational.
// Backpressure: dev_in_ready drops while FGI is set (device holds data); dev_out_valid holds until dev_out_ack.
module io_port_register #(
  parameter int WIDTH     = 8,
  parameter int BUS_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] cpu_bus,
  input  logic                 cpu_inp,
  input  logic                 cpu_out,
  input  logic                 cpu_ion,
  input  logic                 cpu_iof,
  input  logic                 cpu_int_ack,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     inpr_out,
  output logic                 fgi,
  output logic                 fgo,
  output logic                 ien,
  output logic                 irq,
  output logic                 err,
  input  logic [WIDTH-1:0]     dev_in_data,
  input  logic                 dev_in_valid,
  output logic                 dev_in_ready,
  output logic [WIDTH-1:0]     dev_out_data,
  output logic                 dev_out_valid,
  input  logic                 dev_out_ack,
  output logic [CNT_WIDTH-1:0] in_count,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0] inpr;
  logic [WIDTH-1:0] outr;

  // Decoded strobes, each already qualified by the one-hot check and flag state.
  logic multi_cmd;
  logic inp_ok;
  logic inp_bad;
  logic out_ok;
  logic out_bad;
  logic ion_ok;
  logic iof_ok;
  logic capture;
  logic ack_ok;
  logic err_set;

  // Upper bus bits are never used by OUT; fold them into a dummy net.
  generate
    if (BUS_WIDTH > WIDTH) begin : g_bus_hi
      logic unused_bus_hi;
      assign unused_bus_hi = ^cpu_bus[BUS_WIDTH-1:WIDTH];
    end
  endgenerate

  // Command decode: any two of the one-hot commands cancel all of them and raise an error.
  always_comb begin
    multi_cmd = (cpu_inp & cpu_out) | (cpu_inp & cpu_ion) | (cpu_inp & cpu_iof) |
                (cpu_out & cpu_ion) | (cpu_out & cpu_iof) | (cpu_ion & cpu_iof);
    inp_ok    = cpu_inp & ~multi_cmd &  fgi;
    inp_bad   = cpu_inp & ~multi_cmd & ~fgi;
    out_ok    = cpu_out & ~multi_cmd &  fgo;
    out_bad   = cpu_out & ~multi_cmd & ~fgo;
    ion_ok    = cpu_ion & ~multi_cmd;
    iof_ok    = cpu_iof & ~multi_cmd;
    // Capture uses the current FGI, so a same-cycle INP cannot open the door early.
    capture   = dev_in_valid & ~fgi;
    // An ack while FGO is already set is meaningless and silently dropped.
    ack_ok    = dev_out_ack & ~fgo;
    err_set   = multi_cmd | inp_bad | out_bad;
  end

  // Input side: capture a device character into INPR and raise FGI; INP clears FGI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr     <= '0;
      fgi      <= 1'b0;
      in_count <= '0;
    end else if (capture) begin
      inpr     <= dev_in_data;
      fgi      <= 1'b1;
      in_count <= in_count + CNT_ONE;
    end else if (inp_ok) begin
      fgi      <= 1'b0;
    end
  end

  // Output side: OUT loads OUTR and clears FGO; device ack sets FGO (also alongside a failed OUT).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outr      <= '0;
      fgo       <= 1'b1;
      out_count <= '0;
    end else if (out_ok) begin
      outr      <= cpu_bus[WIDTH-1:0];
      fgo       <= 1'b0;
      out_count <= out_count + CNT_ONE;
    end else if (ack_ok) begin
      fgo       <= 1'b1;
    end
  end

  // Interrupt enable: interrupt-cycle acknowledge wins over ION.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien <= 1'b0;
    end else if (cpu_int_ack) begin
      ien <= 1'b0;
    end else if (ion_ok) begin
      ien <= 1'b1;
    end else if (iof_ok) begin
      ien <= 1'b0;
    end
  end

  // Sticky error: a new error beats a concurrent clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Status and data outputs follow the registers with no added latency.
  always_comb begin
    inpr_out      = inpr;
    dev_out_data  = outr;
    dev_in_ready  = ~fgi;
    dev_out_valid = ~fgo;
    irq           = ien & (fgi | fgo);
  end

endmodule

// File: tb/tb_io_port_register.sv
module tb_io_port_register;

  localparam int W  = 8;
  localparam int BW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] cpu_bus;
  logic          cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack, err_clr;
  logic [W-1:0]  inpr_out;
  logic          fgi, fgo, ien, irq, err;
  logic [W-1:0]  dev_in_data;
  logic          dev_in_valid, dev_in_ready;
  logic [W-1:0]  dev_out_data;
  logic          dev_out_valid, dev_out_ack;
  logic [CW-1:0] in_count, out_count;

  typedef struct {
    logic [W-1:0]  inpr;
    logic [W-1:0]  outr;
    logic          fgi;
    logic          fgo;
    logic          ien;
    logic          err;
    logic [CW-1:0] ic;
    logic [CW-1:0] oc;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  io_port_register #(.WIDTH(W), .BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cpu_bus(cpu_bus),
    .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ion(cpu_ion), .cpu_iof(cpu_iof),
    .cpu_int_ack(cpu_int_ack), .err_clr(err_clr),
    .inpr_out(inpr_out), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq), .err(err),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ack(dev_out_ack),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every DUT output against it.
  task automatic compare_state(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check({tag, ".inpr"},       32'(inpr_out),      32'(x.inpr));
    check({tag, ".outr"},       32'(dev_out_data),  32'(x.outr));
    check({tag, ".fgi"},        32'(fgi),           32'(x.fgi));
    check({tag, ".fgo"},        32'(fgo),           32'(x.fgo));
    check({tag, ".ien"},        32'(ien),           32'(x.ien));
    check({tag, ".irq"},        32'(irq),           32'(x.ien & (x.fgi | x.fgo)));
    check({tag, ".err"},        32'(err),           32'(x.err));
    check({tag, ".in_ready"},   32'(dev_in_ready),  32'(!x.fgi));
    check({tag, ".out_valid"},  32'(dev_out_valid), 32'(!x.fgo));
    check({tag, ".in_count"},   32'(in_count),      32'(x.ic));
    check({tag, ".out_count"},  32'(out_count),     32'(x.oc));
  endtask

  task automatic clear_inputs();
    cpu_bus = '0; cpu_inp = 0; cpu_out = 0; cpu_ion = 0; cpu_iof = 0;
    cpu_int_ack = 0; err_clr = 0; dev_in_data = '0; dev_in_valid = 0; dev_out_ack = 0;
  endtask

  // Inputs are already driven (after a negedge); push the expectation, take one edge, compare.
  task automatic step(input string tag);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_state(tag);
    clear_inputs();
  endtask

  task automatic reset_exp();
    e.inpr = '0; e.outr = '0; e.fgi = 0; e.fgo = 1; e.ien = 0; e.err = 0; e.ic = '0; e.oc = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    reset_exp();
    sb.push_back(e);
    compare_state("reset");
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Input handshake.
    @(negedge clk); dev_in_data = 8'h5A; dev_in_valid = 1;
    e.inpr = 8'h5A; e.fgi = 1; e.ic = 2'd1; step("in_first");
    @(negedge clk); dev_in_data = 8'h33; dev_in_valid = 1;
    step("in_held");
    @(negedge clk); dev_in_data = 8'h33; dev_in_valid = 1; cpu_inp = 1;
    e.fgi = 0; step("inp_no_same_edge_capture");
    @(negedge clk); dev_in_data = 8'h33; dev_in_valid = 1;
    e.inpr = 8'h33; e.fgi = 1; e.ic = 2'd2; step("in_second");

    // Output handshake.
    @(negedge clk); cpu_bus = 16'hFF42; cpu_out = 1;
    e.outr = 8'h42; e.fgo = 0; e.oc = 2'd1; step("out_first");
    @(negedge clk); cpu_bus = 16'h0077; cpu_out = 1;
    e.err = 1; step("out_busy_err");
    @(negedge clk); dev_out_ack = 1;
    e.fgo = 1; step("out_ack");
    @(negedge clk); err_clr = 1;
    e.err = 0; step("err_clr1");
    @(negedge clk); cpu_bus = 16'h1299; cpu_out = 1; dev_out_ack = 1;
    e.outr = 8'h99; e.fgo = 0; e.oc = 2'd2; step("out_with_idle_ack");
    @(negedge clk); cpu_bus = 16'h0055; cpu_out = 1; dev_out_ack = 1;
    e.fgo = 1; e.err = 1; step("out_err_with_ack");
    @(negedge clk); err_clr = 1;
    e.err = 0; step("err_clr2");

    // INP on an empty INPR is illegal.
    @(negedge clk); cpu_inp = 1;
    e.fgi = 0; step("inp_ok");
    @(negedge clk); cpu_inp = 1;
    e.err = 1; step("inp_empty_err");
    @(negedge clk); err_clr = 1;
    e.err = 0; step("err_clr3");

    // Interrupts.
    @(negedge clk); cpu_bus = 16'h0010; cpu_out = 1;
    e.outr = 8'h10; e.fgo = 0; e.oc = 2'd3; step("out_third");
    @(negedge clk); cpu_ion = 1;
    e.ien = 1; step("ion_no_irq");
    @(negedge clk); dev_in_data = 8'h61; dev_in_valid = 1;
    e.inpr = 8'h61; e.fgi = 1; e.ic = 2'd3; step("irq_on_char");
    @(negedge clk); cpu_int_ack = 1; cpu_ion = 1;
    e.ien = 0; step("int_ack_beats_ion");
    @(negedge clk); cpu_ion = 1;
    e.ien = 1; step("ion");
    @(negedge clk); cpu_iof = 1;
    e.ien = 0; step("iof");

    // Illegal combinations.
    @(negedge clk); cpu_bus = 16'h00AA; cpu_inp = 1; cpu_out = 1;
    e.err = 1; step("inp_out_combo");
    @(negedge clk); err_clr = 1; cpu_iof = 1; cpu_ion = 1;
    step("clr_vs_new_err");
    @(negedge clk); err_clr = 1;
    e.err = 0; step("err_clr4");

    // Set up fgi=1, outr=41 and wrap out_count before the async reset.
    @(negedge clk); dev_out_ack = 1;
    e.fgo = 1; step("ack_before_reset");
    @(negedge clk); cpu_bus = 16'h0041; cpu_out = 1;
    e.outr = 8'h41; e.fgo = 0; e.oc = 2'd0; step("out_count_wrap");

    // Mid-cycle asynchronous reset takes effect without a clock edge.
    @(posedge clk); #2;
    rst = 1;
    #1;
    reset_exp();
    sb.push_back(e);
    compare_state("async_reset");
    @(negedge clk);
    rst = 0;

    // Five accepted inputs on a 2-bit counter wrap to 1.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); dev_in_data = W'(8'hC0 + i); dev_in_valid = 1;
      e.inpr = W'(8'hC0 + i); e.fgi = 1; e.ic = e.ic + 2'd1; step($sformatf("wrap_cap%0d", i));
      @(negedge clk); cpu_inp = 1;
      e.fgi = 0; step($sformatf("wrap_inp%0d", i));
    end
    check("in_count_wrap_final", 32'(in_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_register.md
Name: io_port_register

Overview:
- Parametrised input/output port for the basic computer.
- Holds the input register (INPR) with its input flag (FGI), and the output register (OUTR) with its output flag (FGO).
- Adds behaviour the plain I/O register lacks: device-side valid/ready handshakes, an interrupt-enable flip-flop with interrupt request, a sticky illegal-command error flag, and wrapping transfer counters.
- Sits between the CPU control unit / AC bus and the external character device.

Parameters:
- WIDTH, 8, width of INPR, OUTR and device data.
- BUS_WIDTH, 16, width of the CPU common bus; must be >= WIDTH.
- CNT_WIDTH, 8, width of each transfer counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_bus  in  BUS_WIDTH  AC value; bits [WIDTH-1:0] are used by OUT.
- cpu_inp  in  1  INP/acknowledge command: consume INPR, clear FGI.
- cpu_out  in  1  OUT command: load OUTR from cpu_bus, clear FGO.
- cpu_ion  in  1  set IEN.
- cpu_iof  in  1  clear IEN.
- cpu_int_ack  in  1  interrupt cycle taken: clear IEN.
- err_clr  in  1  clear the sticky error flag.
- inpr_out  out  WIDTH  INPR contents.
- fgi  out  1  input flag.
- fgo  out  1  output flag.
- ien  out  1  interrupt enable.
- irq  out  1  interrupt request.
- err  out  1  sticky illegal-command flag.
- dev_in_data  in  WIDTH  device input character.
- dev_in_valid  in  1  device offers a character.
- dev_in_ready  out  1  port accepts a character.
- dev_out_data  out  WIDTH  OUTR contents to the device.
- dev_out_valid  out  1  OUTR holds an unconsumed character.
- dev_out_ack  in  1  device consumed OUTR.
- in_count  out  CNT_WIDTH  accepted device inputs, modulo 2^CNT_WIDTH.
- out_count  out  CNT_WIDTH  executed OUT commands, modulo 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) forces:
  - inpr=0, outr=0, fgi=0, fgo=1 (device ready), ien=0, err=0, in_count=0, out_count=0.
  - Outputs then read dev_in_ready=1, dev_out_valid=0, irq=0.
- Combinational outputs: dev_in_ready=!fgi; dev_out_valid=!fgo; dev_out_data=outr; inpr_out=inpr; irq=ien&(fgi|fgo). No added latency.
- Device input:
  - Edge with dev_in_valid=1 and fgi=0: inpr<=dev_in_data, fgi<=1, in_count<=in_count+1 (wraps).
  - dev_in_valid=1 while fgi=1: nothing captured; the device must hold its data.
- CPU commands: cpu_inp, cpu_out, cpu_ion and cpu_iof are one-hot.
  - Two or more asserted in one cycle: none executes, err<=1.
- cpu_inp alone:
  - fgi=1: fgi<=0.
  - fgi=0: err<=1, no state change.
  - In the cycle cpu_inp clears FGI, dev_in_ready is still 0, so no capture occurs that same edge; capture is possible from the next edge.
- cpu_out alone:
  - fgo=1: outr<=cpu_bus[WIDTH-1:0], fgo<=0, out_count<=out_count+1 (wraps).
  - fgo=0: err<=1, outr and fgo unchanged.
- dev_out_ack:
  - fgo=0: fgo<=1.
  - fgo=1: ignored, no error.
  - Same cycle as a cpu_out that errors (fgo=0): the ack still sets fgo, and err is set.
- IEN:
  - cpu_ion sets it; cpu_iof clears it.
  - cpu_int_ack clears it and has priority over cpu_ion in the same cycle.
  - cpu_int_ack is not part of the one-hot check.
- err:
  - Sticky; err_clr clears it.
  - err_clr in the same cycle as a new error: err stays 1.
- Upper bits cpu_bus[BUS_WIDTH-1:WIDTH] are ignored.

Test Plan:
- Reset: assert rst mid-cycle with fgi=1, outr=8'h41 -> immediately inpr=0, outr=0, fgi=0, fgo=1, ien=0, irq=0, err=0, counts=0.
- Input handshake: dev_in_data=8'h5A, dev_in_valid=1 -> next edge inpr_out=8'h5A, fgi=1, dev_in_ready=0, in_count=1. Second char 8'h33 held -> not captured. cpu_inp -> fgi=0. Next edge 8'h33 captured, in_count=2.
- Output handshake: cpu_bus=16'hFF42, cpu_out -> outr=8'h42, fgo=0, dev_out_valid=1, out_count=1. Second cpu_out -> err=1, outr stays 8'h42. dev_out_ack -> fgo=1.
- Interrupt: cpu_ion, then device char -> irq=1. cpu_int_ack together with cpu_ion -> ien=0, irq=0.
- Illegal combos: cpu_inp+cpu_out together -> err=1, fgi/fgo/outr unchanged. err_clr with concurrent cpu_iof+cpu_ion -> err remains 1. err_clr alone -> err=0.
- Counter wrap: CNT_WIDTH=2, five accepted inputs -> in_count=1.
